// File: rtl/counter_gen.sv
// Parametrised up/down counter with wrap, saturate and one-shot modes, sync load, sticky ovf and tc pulse.
// Optional parity output: define COUNTER_GEN_PARITY_EN to register the XOR-reduce of count.
module counter_gen #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 2**WIDTH-1,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             done,
  output logic             parity
);

  localparam logic [WIDTH-1:0] LIM_W     = WIDTH'(LIMIT);
  localparam logic [WIDTH:0]   LIM_X     = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MOD_X     = LIM_X + {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   DN_WRAP_X = MOD_X - STEP_X;
  localparam logic [1:0]       MODE_SAT  = 2'd1;
  localparam logic [1:0]       MODE_ONE  = 2'd2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             ovf_r;
  logic [WIDTH-1:0] count_next_s;
  logic             tc_next_s;
  logic             ovf_set_s;

  logic [WIDTH:0]   cnt_x_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   dn_diff_s;
  logic [WIDTH:0]   up_wrap_s;
  logic [WIDTH:0]   dn_wrap_s;
  logic             up_over_s;
  logic             dn_under_s;
  logic             one_hit_s;
  logic             active_s;
  logic [WIDTH-1:0] load_clamp_s;

  // Step arithmetic is one bit wider than count so nothing truncates before the bound test.
  assign cnt_x_s      = {1'b0, count_r};
  assign up_sum_s     = cnt_x_s + STEP_X;
  assign dn_diff_s    = cnt_x_s - STEP_X;
  assign up_wrap_s    = up_sum_s - MOD_X;
  assign dn_wrap_s    = cnt_x_s + DN_WRAP_X;
  assign up_over_s    = (up_sum_s > LIM_X);
  assign dn_under_s   = (cnt_x_s < STEP_X);
  assign one_hit_s    = up ? (up_sum_s >= LIM_X) : (cnt_x_s <= STEP_X);
  assign active_s     = en & ~((state_r == ST_DONE) & (mode == MODE_ONE));
  assign load_clamp_s = ({1'b0, load_val} > LIM_X) ? LIM_W : load_val;

  // One-shot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // One-shot next state: load re-arms, reaching the bound in one-shot mode finishes.
  always_comb begin
    state_next_s = state_r;
    if (load) begin
      state_next_s = ST_RUN;
    end else if (active_s && (mode == MODE_ONE) && one_hit_s) begin
      state_next_s = ST_DONE;
    end else begin
      state_next_s = state_r;
    end
  end

  // Next count, terminal-count pulse and overflow-set for the coming edge.
  always_comb begin
    count_next_s = count_r;
    tc_next_s    = 1'b0;
    ovf_set_s    = 1'b0;
    if (load) begin
      count_next_s = load_clamp_s;
    end else if (active_s) begin
      case (mode)
        MODE_ONE: begin
          if (one_hit_s) begin
            count_next_s = up ? LIM_W : {WIDTH{1'b0}};
            tc_next_s    = 1'b1;
          end else begin
            count_next_s = up ? up_sum_s[WIDTH-1:0] : dn_diff_s[WIDTH-1:0];
          end
        end
        MODE_SAT: begin
          if (up ? up_over_s : dn_under_s) begin
            count_next_s = up ? LIM_W : {WIDTH{1'b0}};
            tc_next_s    = 1'b1;
            ovf_set_s    = 1'b1;
          end else begin
            count_next_s = up ? up_sum_s[WIDTH-1:0] : dn_diff_s[WIDTH-1:0];
          end
        end
        default: begin
          if (up ? up_over_s : dn_under_s) begin
            count_next_s = up ? up_wrap_s[WIDTH-1:0] : dn_wrap_s[WIDTH-1:0];
            tc_next_s    = 1'b1;
            ovf_set_s    = 1'b1;
          end else begin
            count_next_s = up ? up_sum_s[WIDTH-1:0] : dn_diff_s[WIDTH-1:0];
          end
        end
      endcase
    end else begin
      count_next_s = count_r;
    end
  end

  // Output registers; a crossing wins over clr_ovf in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tc_r    <= tc_next_s;
      ovf_r   <= ovf_set_s | (ovf_r & ~clr_ovf);
    end
  end

`ifdef COUNTER_GEN_PARITY_EN
  logic parity_r;

  // Parity tracks the value being written into count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= ^count_next_s;
    end
  end

  assign parity = parity_r;
`else
  assign parity = 1'b0;
`endif

  assign count = count_r;
  assign tc    = tc_r;
  assign ovf   = ovf_r;
  assign done  = (state_r == ST_DONE);

endmodule

// File: tb/tb_counter_gen.sv
// Bench for counter_gen: two instances (STEP=1 and STEP=4, LIMIT=9) checked every cycle
// against an integer model, plus directed literal expectations.
module tb_counter_gen;
  localparam int W   = 8;
  localparam int LIM = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = 8'd0;
  logic         clr_ovf = 1'b0;

  logic [W-1:0] count1, count4;
  logic         tc1, ovf1, done1, par1;
  logic         tc4, ovf4, done4, par4;

  int checks = 0;
  int failures = 0;

  counter_gen #(.WIDTH(W), .LIMIT(LIM), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count1), .tc(tc1),
    .ovf(ovf1), .done(done1), .parity(par1));

  counter_gen #(.WIDTH(W), .LIMIT(LIM), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count4), .tc(tc4),
    .ovf(ovf4), .done(done4), .parity(par4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_par(input int c);
    logic [W-1:0] v;
    v = c[W-1:0];
`ifdef COUNTER_GEN_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  // Integer model: one entry per instance
  int  m_cnt[2];
  bit  m_tc[2], m_ovf[2], m_done[2];
  int  steps[2] = '{1, 4};
  int  mn;
  bit  mcross;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mcross = 0;
        m_tc[k] = 0;
        if (load) begin
          m_cnt[k] = (int'(load_val) > LIM) ? LIM : int'(load_val);
          m_done[k] = 0;
        end else if (en && !(mode == 2'd2 && m_done[k])) begin
          mn = up ? m_cnt[k] + steps[k] : m_cnt[k] - steps[k];
          if (mode == 2'd2) begin
            if (up ? (mn >= LIM) : (mn <= 0)) begin
              m_cnt[k] = up ? LIM : 0; m_tc[k] = 1; m_done[k] = 1;
            end else m_cnt[k] = mn;
          end else if (mn > LIM || mn < 0) begin
            m_tc[k] = 1; mcross = 1;
            if (mode == 2'd1) m_cnt[k] = up ? LIM : 0;
            else m_cnt[k] = (mn > LIM) ? mn - (LIM + 1) : mn + (LIM + 1);
          end else m_cnt[k] = mn;
        end
        m_ovf[k] = mcross | (m_ovf[k] & !clr_ovf);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count1", count1, m_cnt[0]);
    chk("m_tc1", tc1, m_tc[0]);
    chk("m_ovf1", ovf1, m_ovf[0]);
    chk("m_done1", done1, m_done[0]);
    chk("m_par1", par1, exp_par(m_cnt[0]));
    chk("m_count4", count4, m_cnt[1]);
    chk("m_tc4", tc4, m_tc[1]);
    chk("m_ovf4", ovf4, m_ovf[1]);
    chk("m_done4", done4, m_done[1]);
    chk("m_par4", par4, exp_par(m_cnt[1]));
  end

  task automatic drive(input bit e, input bit u, input logic [1:0] md, input bit ld,
                       input logic [W-1:0] lv, input bit clr);
    en = e; up = u; mode = md; load = ld; load_val = lv; clr_ovf = clr;
    @(negedge clk);
  endtask

  int exp1[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int expp[12]  = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  int sat_c[4]  = '{1, 0, 0, 0};
  int sat_t[4]  = '{0, 0, 1, 1};
  int one_c[5]  = '{8, 9, 9, 9, 9};
  int one_d[5]  = '{0, 1, 1, 1, 1};
  int one_t[5]  = '{0, 1, 0, 0, 0};

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", count1, 0);
    chk("rst_tc", tc1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_done", done1, 0);
    chk("rst_par", par1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 2'd0, 0, 8'd0, 0);
      chk("wrap_count", count1, exp1[i]);
      chk("wrap_tc", tc1, (exp1[i] == 0) ? 1 : 0);
      chk("wrap_ovf", ovf1, (i >= 9) ? 1 : 0);
`ifdef COUNTER_GEN_PARITY_EN
      chk("wrap_par", par1, expp[i]);
`endif
    end

    drive(0, 1, 2'd0, 0, 8'd0, 1);
    chk("clr_ovf", ovf1, 0);
    drive(0, 1, 2'd1, 1, 8'd2, 0);
    chk("sat_load", count1, 2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'd1, 0, 8'd0, 0);
      chk("sat_count", count1, sat_c[i]);
      chk("sat_tc", tc1, sat_t[i]);
      chk("sat_ovf", ovf1, sat_t[i]);
    end

    drive(0, 1, 2'd2, 1, 8'd7, 1);
    chk("one_load", count1, 7);
    chk("one_ovf_clr", ovf1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 2'd2, 0, 8'd0, 0);
      chk("one_count", count1, one_c[i]);
      chk("one_done", done1, one_d[i]);
      chk("one_tc", tc1, one_t[i]);
    end
    chk("one_no_ovf", ovf1, 0);
    chk("one_count4", count4, 9);
    drive(0, 1, 2'd2, 1, 8'd3, 0);
    chk("one_reload", count1, 3);
    chk("one_rearm", done1, 0);

    drive(1, 1, 2'd0, 1, 8'd15, 0);
    chk("clamp_count", count1, 9);
    chk("clamp_tc", tc1, 0);
    chk("clamp_count4", count4, 9);

    drive(0, 1, 2'd0, 0, 8'd0, 1);
    drive(1, 1, 2'd0, 0, 8'd0, 1);
    chk("setclr_count", count1, 0);
    chk("setclr_tc", tc1, 1);
    chk("setclr_ovf", ovf1, 1);
    chk("setclr_count4", count4, 3);
    drive(0, 1, 2'd0, 0, 8'd0, 1);
    chk("clr_only_ovf", ovf1, 0);
    chk("idle_tc", tc1, 0);

    drive(0, 1, 2'd0, 1, 8'd8, 0);
    drive(1, 1, 2'd0, 0, 8'd0, 0);
    chk("s4_up_count", count4, 2);
    chk("s4_up_tc", tc4, 1);
    drive(0, 1, 2'd0, 1, 8'd2, 0);
    drive(1, 0, 2'd0, 0, 8'd0, 0);
    chk("s4_dn_count", count4, 8);
    chk("s4_dn_tc", tc4, 1);

    drive(0, 1, 2'd3, 1, 8'd9, 0);
    drive(1, 1, 2'd3, 0, 8'd0, 0);
    chk("m3_count", count1, 0);
    chk("m3_tc", tc1, 1);
    drive(0, 1, 2'd1, 1, 8'd9, 0);
    drive(1, 1, 2'd1, 0, 8'd0, 0);
    chk("sat_hold_count", count1, 9);
    chk("sat_hold_tc", tc1, 1);
    drive(1, 1, 2'd0, 0, 8'd0, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count1, 0);
    chk("arst_tc", tc1, 0);
    chk("arst_ovf", ovf1, 0);
    chk("arst_count4", count4, 0);
    chk("arst_par", par1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 2'd0, 0, 8'd0, 0);
    chk("post_rst_count", count1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
